// File: rtl/ins_fetch_queue.sv
// ins_fetch_queue
//   Instruction prefetch front end. Issues sequential word addresses to
//   instruction RAM, keeps the returned words and their PCs in a DEPTH-entry
//   FIFO for decode, and handles branch redirect by flushing the FIFO and
//   refetching from the new PC.
//
//   state | meaning
//   IDLE  | no request outstanding; issue when enabled and FIFO has room
//   REQ   | request outstanding; its returned word is pushed to the FIFO
//   DRAIN | request outstanding but made stale by a redirect; word is dropped
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   en_in                     fetch enable (0 = issue no new requests)
//   mem_req, mem_addr         registered RAM request, held until mem_valid
//   mem_valid, mem_rdata      RAM response strobe and data
//   redirect, redirect_pc     branch taken: flush and refetch from redirect_pc
//   ins_valid, ins, ins_pc    FIFO head towards decode
//   ins_ready                 decode accepts the head
//   level                     current FIFO occupancy
module ins_fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                INS_W    = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_in,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_valid,
  input  logic [INS_W-1:0]           mem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       ins_valid,
  output logic [INS_W-1:0]           ins,
  output logic [ADDR_W-1:0]          ins_pc,
  input  logic                       ins_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_next;
  logic              push;
  logic              pop;
  logic              room_now;
  logic              room_next;

  logic [INS_W-1:0]  fifo_ins [DEPTH];
  logic [ADDR_W-1:0] fifo_pc  [DEPTH];

  // pc always equals mem_addr while in REQ, so it tags the returned word.
  assign pc_inc    = pc + ADDR_W'(1);
  assign ins_valid = (level != '0);
  assign ins       = fifo_ins[rd_ptr];
  assign ins_pc    = fifo_pc[rd_ptr];

  // A redirect cancels both the push and the pop of its cycle.
  assign push = (state == REQ) && mem_req && mem_valid && !redirect;
  assign pop  = ins_valid && ins_ready && !redirect;

  always_comb begin
    level_next = level;
    if (redirect)
      level_next = '0;
    else if (push && !pop)
      level_next = level + LVL_W'(1);
    else if (pop && !push)
      level_next = level - LVL_W'(1);
  end

  assign room_now  = (level < LVL_W'(DEPTH));
  // Back-to-back issue looks at occupancy after this cycle's push/pop, which
  // together with a single outstanding request makes overflow impossible.
  assign room_next = (level_next < LVL_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ins[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]  <= pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      level    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      level <= level_next;

      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (en_in) begin
              mem_req  <= 1'b1;
              mem_addr <= redirect_pc;
              state    <= REQ;
            end
          end else if (en_in && room_now) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
            state    <= REQ;
          end
        end

        REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (mem_valid) begin
              // Transfer completes now; its word is discarded and the new
              // target can be issued straight away.
              if (en_in) begin
                mem_addr <= redirect_pc;
              end else begin
                mem_req <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              // Request still in flight: hold it until the RAM answers.
              state <= DRAIN;
            end
          end else if (mem_valid) begin
            pc <= pc_inc;
            if (en_in && room_next) begin
              mem_addr <= pc_inc;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end

        DRAIN: begin
          if (redirect) pc <= redirect_pc;
          if (mem_valid) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch_queue.sv
module tb_ins_fetch_queue;

  logic        clk;
  logic        rst;
  logic        en_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ins_valid;
  logic [15:0] ins;
  logic [15:0] ins_pc;
  logic        ins_ready;
  logic [2:0]  level;

  logic        en4;
  logic        mem_req4;
  logic [3:0]  mem_addr4;
  logic        mem_valid4;
  logic [15:0] mem_rdata4;
  logic        redirect4;
  logic [3:0]  redirect_pc4;
  logic        ins_valid4;
  logic [15:0] ins4;
  logic [3:0]  ins_pc4;
  logic        ins_ready4;
  logic [2:0]  level4;

  int n_checks;
  int n_errors;
  int ram_wait;
  int wcnt;
  int fire_cnt;
  logic [15:0] last_addr;

  ins_fetch_queue #(.ADDR_W(16), .INS_W(16), .DEPTH(4), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .en_in(en_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready), .level(level)
  );

  ins_fetch_queue #(.ADDR_W(4), .INS_W(16), .DEPTH(4), .RESET_PC(4'd14)) u_dut4 (
    .clk(clk), .rst(rst), .en_in(en4),
    .mem_req(mem_req4), .mem_addr(mem_addr4), .mem_valid(mem_valid4), .mem_rdata(mem_rdata4),
    .redirect(redirect4), .redirect_pc(redirect_pc4),
    .ins_valid(ins_valid4), .ins(ins4), .ins_pc(ins_pc4), .ins_ready(ins_ready4), .level(level4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: word = addr + 0x100, answers after ram_wait idle cycles.
  assign mem_valid  = mem_req && (wcnt == ram_wait);
  assign mem_rdata  = mem_addr + 16'h0100;
  assign mem_valid4 = mem_req4;
  assign mem_rdata4 = {12'h000, mem_addr4} + 16'h0100;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt      <= 0;
      fire_cnt  <= 0;
      last_addr <= 16'h0;
    end else if (mem_req && mem_valid) begin
      wcnt      <= 0;
      fire_cnt  <= fire_cnt + 1;
      last_addr <= mem_addr;
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_in    = 1'b0;
    en4      = 1'b0;
    redirect = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    ram_wait     = 0;
    rst          = 1'b1;
    en_in        = 1'b0;
    en4          = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 16'h0;
    redirect4    = 1'b0;
    redirect_pc4 = 4'h0;
    ins_ready    = 1'b0;
    ins_ready4   = 1'b1;

    // Reset state
    step();
    step();
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_addr4",     32'(mem_addr4), 32'd14);
    rst = 1'b0;

    // 1: zero-wait streaming, one word per cycle
    do_reset();
    en_in = 1'b1;
    ins_ready = 1'b1;
    step();
    check("t1_req",       32'(mem_req),   32'd1);
    check("t1_addr0",     32'(mem_addr),  32'h0);
    check("t1_not_valid", 32'(ins_valid), 32'd0);
    step();
    check("t1_valid",     32'(ins_valid), 32'd1);
    check("t1_pc0",       32'(ins_pc),    32'h0);
    check("t1_ins0",      32'(ins),       32'h0100);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t1_pc",    32'(ins_pc), 32'(k));
      check("t1_ins",   32'(ins),    32'(16'h0100 + k));
      check("t1_level", 32'(level),  32'd1);
    end

    // 2: decode stalled, FIFO fills to DEPTH, then refill resumes at 4
    do_reset();
    ins_ready = 1'b0;
    en_in = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("t2_fires",     32'(fire_cnt),  32'd4);
    check("t2_last_addr", 32'(last_addr), 32'd3);
    check("t2_level",     32'(level),     32'd4);
    check("t2_req_low",   32'(mem_req),   32'd0);
    check("t2_head_pc",   32'(ins_pc),    32'd0);
    ins_ready = 1'b1;
    step();
    check("t2_pop_level", 32'(level),   32'd3);
    check("t2_pop_req",   32'(mem_req), 32'd0);
    check("t2_pop_pc",    32'(ins_pc),  32'd1);
    step();
    check("t2_refill_req",  32'(mem_req),  32'd1);
    check("t2_refill_addr", 32'(mem_addr), 32'd4);
    check("t2_refill_lvl",  32'(level),    32'd2);

    // 3: 3 wait states, redirect during first wait cycle
    do_reset();
    ram_wait = 3;
    ins_ready = 1'b1;
    en_in = 1'b1;
    step();
    check("t3_req",  32'(mem_req),  32'd1);
    check("t3_addr", 32'(mem_addr), 32'h0);
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_req",  32'(mem_req),  32'd1);
      check("t3_hold_addr", 32'(mem_addr), 32'h0);
      step();
    end
    check("t3_drop_req",   32'(mem_req),   32'd0);
    check("t3_drop_valid", 32'(ins_valid), 32'd0);
    step();
    check("t3_new_req",  32'(mem_req),  32'd1);
    check("t3_new_addr", 32'(mem_addr), 32'h20);
    for (int k = 0; k < 20 && !ins_valid; k++) step();
    check("t3_wait_ins_valid", 32'(ins_valid), 32'd1);
    check("t3_first_pc",  32'(ins_pc), 32'h20);
    check("t3_first_ins", 32'(ins),    32'h0120);
    ram_wait = 0;

    // 4: redirect together with mem_valid and pop at level 2
    do_reset();
    ins_ready = 1'b0;
    en_in = 1'b1;
    step();
    step();
    step();
    check("t4_level2",    32'(level),     32'd2);
    check("t4_req",       32'(mem_valid), 32'd1);
    ins_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    check("t4_flush_lvl",   32'(level),     32'd0);
    check("t4_flush_valid", 32'(ins_valid), 32'd0);
    check("t4_req40",       32'(mem_req),   32'd1);
    check("t4_addr40",      32'(mem_addr),  32'h40);
    step();
    check("t4_valid", 32'(ins_valid), 32'd1);
    check("t4_pc40",  32'(ins_pc),    32'h40);
    check("t4_ins40", 32'(ins),       32'h0140);

    // 5: 4-bit PC wraps 14,15,0,1; en falls mid-REQ
    do_reset();
    ins_ready4 = 1'b1;
    en4 = 1'b1;
    step();
    check("t5_addr14", 32'(mem_addr4), 32'd14);
    step();
    check("t5_addr15", 32'(mem_addr4), 32'd15);
    check("t5_pc14",   32'(ins_pc4),   32'd14);
    step();
    check("t5_addr0",  32'(mem_addr4), 32'd0);
    check("t5_pc15",   32'(ins_pc4),   32'd15);
    step();
    check("t5_addr1",  32'(mem_addr4), 32'd1);
    check("t5_pc0",    32'(ins_pc4),   32'd0);
    check("t5_ins0",   32'(ins4),      32'h0100);
    en4 = 1'b0;
    step();
    check("t5_last_req", 32'(mem_req4),   32'd0);
    check("t5_last_pc",  32'(ins_pc4),    32'd1);
    check("t5_last_vld", 32'(ins_valid4), 32'd1);
    step();
    check("t5_idle_req", 32'(mem_req4),   32'd0);
    check("t5_empty",    32'(ins_valid4), 32'd0);

    // 6: async reset between edges mid-REQ
    do_reset();
    ins_ready = 1'b0;
    en_in = 1'b1;
    step();
    step();
    step();
    check("t6_pre_level", 32'(level),   32'd2);
    check("t6_pre_req",   32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_req",   32'(mem_req),   32'd0);
    check("t6_async_level", 32'(level),     32'd0);
    check("t6_async_valid", 32'(ins_valid), 32'd0);
    check("t6_async_addr",  32'(mem_addr),  32'h0);
    step();
    rst = 1'b0;
    step();
    check("t6_restart_req",  32'(mem_req),  32'd1);
    check("t6_restart_addr", 32'(mem_addr), 32'h0);
    step();
    check("t6_restart_pc",  32'(ins_pc), 32'h0);
    check("t6_restart_lvl", 32'(level),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
